ifetch_prefetch: RTL and testbench

Instruction prefetch stage between an instruction memory with a request/response handshake and the CPU's decode logic. It keeps a program counter, issues in-order word fetches ahead of consumption, and buffers returned instructions with their PCs in a small FIFO. On a taken branch or jump redirect it flushes the FIFO, discards responses still in flight, and restarts fetching at the new PC.

---
 rtl/ifetch_prefetch.sv | 125 ++++++++++++
 tb/tb_ifetch_prefetch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_prefetch.sv
// Instruction prefetch stage: credit-limited in-order fetch, PC-tagged FIFO, redirect flush.
// Define IFETCH_PERF_EN to build the stall/discard performance counters.
module ifetch_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_discard_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pcs_q  [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW:0]   credit;
  logic          req_fire, rsp_fire, drop, push, pop;
  logic [31:0]   redir_pc;

  // Credits cover buffered plus in-flight words, so a push never meets a full FIFO
  always_comb begin
    credit         = {1'b0, cnt_q} + {1'b0, out_q};
    imem_req_valid = ~reset & (credit < DEPTH_C);
    imem_addr      = fetch_pc_q;
    req_fire       = imem_req_valid & imem_req_ready;
    rsp_fire       = imem_rsp_valid & (out_q != '0);
    drop           = rsp_fire & (redirect_valid | (disc_q != '0));
    push           = rsp_fire & ~drop;
    instr_valid    = cnt_q != '0;
    pop            = instr_valid & instr_ready & ~redirect_valid;
    instr          = instr_valid ? data_q[rd_q] : '0;
    instr_pc       = instr_valid ? pcs_q[rd_q] : '0;
    redir_pc       = {redirect_pc[31:2], 2'b00};
  end

  always_comb begin
    out_d      = out_q + CW'(req_fire) - CW'(rsp_fire);
    fetch_pc_d = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
    rsp_pc_d   = push ? rsp_pc_q + 32'd4 : rsp_pc_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    wr_d       = wr_q + AW'(push);
    rd_d       = rd_q + AW'(pop);
    disc_d     = disc_q - CW'(drop);
    // Everything still in flight after this cycle belongs to the old stream
    if (redirect_valid) begin
      fetch_pc_d = redir_pc;
      rsp_pc_d   = redir_pc;
      cnt_d      = '0;
      wr_d       = '0;
      rd_d       = '0;
      disc_d     = out_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      out_q      <= '0;
      disc_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_q] <= imem_rsp_data;
      pcs_q[wr_q]  <= rsp_pc_q;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] disc_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      disc_cnt_q  <= '0;
    end else begin
      if (instr_ready & ~instr_valid)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (drop)
        disc_cnt_q <= disc_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt   = stall_cnt_q;
  assign perf_discard_cnt = disc_cnt_q;
`else
  assign perf_stall_cnt   = '0;
  assign perf_discard_cnt = '0;
`endif

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch with an in-order variable-latency memory model.
// Memory word at address a holds a + 0x1000_0000.
module tb_ifetch_prefetch;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_discard_cnt;

`ifdef IFETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  ifetch_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .reset            (reset),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_addr        (imem_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .perf_stall_cnt   (perf_stall_cnt),
    .perf_discard_cnt (perf_discard_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // memory model: accepts on handshake, answers in order after lat cycles
  logic [31:0] qa[$];
  int          qd[$];
  int          cyc = 0;
  int          lat = 1;
  int          req_cnt = 0;
  logic        mdl_v = 1'b0;
  logic [31:0] mdl_d = 32'h0;
  logic        stray_v = 1'b0;

  assign imem_rsp_valid = mdl_v | stray_v;
  assign imem_rsp_data  = stray_v ? 32'hDEAD_BEEF : mdl_d;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      qa.delete();
      qd.delete();
      req_cnt = 0;
    end else begin
      if (mdl_v) begin
        void'(qa.pop_front());
        void'(qd.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        qa.push_back(imem_addr);
        qd.push_back(cyc + lat - 1);
        req_cnt++;
      end
    end
    #1;
    if (!reset && qa.size() > 0 && qd[0] <= cyc) begin
      mdl_v = 1'b1;
      mdl_d = qa[0] + 32'h1000_0000;
    end else begin
      mdl_v = 1'b0;
      mdl_d = 32'h0;
    end
  end

  task automatic do_reset(input int l, input logic rdy);
    @(negedge clk);
    reset          = 1'b1;
    lat            = l;
    instr_ready    = rdy;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40 && !instr_valid; i++)
      @(negedge clk);
    chk(tag, 32'(instr_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_stall", perf_stall_cnt, 32'h0);
    chk("rst_disc", perf_discard_cnt, 32'h0);

    // streaming with 1-cycle memory
    reset = 1'b0;
    #1;
    chk("s_addr0", imem_addr, 32'h0);
    chk("s_req_valid", 32'(imem_req_valid), 32'd1);
    @(negedge clk);
    chk("s_addr4", imem_addr, 32'h4);
    chk("s_lat_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk("s_addr8", imem_addr, 32'h8);
    chk("s_valid", 32'(instr_valid), 32'd1);
    chk("s_pc0", instr_pc, 32'h0);
    chk("s_ins0", instr, 32'h1000_0000);
    @(negedge clk);
    chk("s_pc4", instr_pc, 32'h4);
    chk("s_ins4", instr, 32'h1000_0004);
    @(negedge clk);
    chk("s_pc8", instr_pc, 32'h8);
    @(negedge clk);
    chk("s_pcC", instr_pc, 32'hC);
    chk("s_stall", perf_stall_cnt, PERF ? 32'd2 : 32'd0);

    // decode stalled: credits cap requests at DEPTH
    do_reset(1, 1'b0);
    repeat (10) @(negedge clk);
    chk("st_reqs", 32'(req_cnt), 32'd4);
    chk("st_req_valid", 32'(imem_req_valid), 32'd0);
    chk("st_valid", 32'(instr_valid), 32'd1);
    chk("st_head_stable", instr_pc, 32'h0);
    instr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("st_pc%0d", k), instr_pc, 32'(4 * k));
      @(negedge clk);
    end

    // 3 outstanding at redirect, none arriving in the redirect cycle
    do_reset(4, 1'b1);
    repeat (3) @(negedge clk);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    chk("rd_addr", imem_addr, 32'h100);
    chk("rd_flush", 32'(instr_valid), 32'd0);
    wait_valid("rd_wait");
    chk("rd_pc", instr_pc, 32'h100);
    chk("rd_ins", instr, 32'h1000_0100);
    chk("rd_disc", perf_discard_cnt, PERF ? 32'd3 : 32'd0);

    // redirect coincident with request and response, unaligned target
    do_reset(1, 1'b1);
    repeat (6) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("co_addr", imem_addr, 32'h200);
    chk("co_flush", 32'(instr_valid), 32'd0);
    wait_valid("co_wait");
    chk("co_pc", instr_pc, 32'h200);
    chk("co_disc", perf_discard_cnt, PERF ? 32'd2 : 32'd0);

    // fetch address wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("wr_addr_top", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wr_addr_zero", imem_addr, 32'h0);
    wait_valid("wr_wait");
    chk("wr_pc_top", instr_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wr_pc_zero", instr_pc, 32'h0);
    chk("wr_ins_zero", instr, 32'h1000_0000);

    // asynchronous reset with a full FIFO
    do_reset(1, 1'b0);
    repeat (8) @(negedge clk);
    chk("ar_full", 32'(instr_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", 32'(instr_valid), 32'd0);
    chk("ar_req_valid", 32'(imem_req_valid), 32'd0);
    chk("ar_pc", instr_pc, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ar_addr", imem_addr, 32'h0);
    chk("ar_req_again", 32'(imem_req_valid), 32'd1);
    instr_ready = 1'b1;
    wait_valid("ar_wait");
    chk("ar_first_pc", instr_pc, 32'h0);

    // response with nothing outstanding is ignored
    do_reset(1, 1'b1);
    imem_req_ready = 1'b0;
    stray_v        = 1'b1;
    repeat (2) @(negedge clk);
    stray_v = 1'b0;
    chk("sy_valid", 32'(instr_valid), 32'd0);
    chk("sy_req_valid", 32'(imem_req_valid), 32'd1);
    imem_req_ready = 1'b1;
    wait_valid("sy_wait");
    chk("sy_pc", instr_pc, 32'h0);
    chk("sy_ins", instr, 32'h1000_0000);
    chk("sy_disc", perf_discard_cnt, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
